// File: rtl/edge_delay_counter.sv
`default_nettype none
// ============================================================================
// Module   : edge_delay_counter
// Purpose  : Measures the delay, in clock cycles, between a rising edge on a
//            reference signal (from_in) and a later rising edge on a response
//            signal (to_in). Both inputs are asynchronous and pass through
//            identical synchronizer + edge-detect paths, so the measured delay
//            is not biased by the input latency. Each arm yields exactly one
//            result (delay or timeout), presented on a valid/ready port.
// Revision : 1.0 - initial release
//
// Ports:
//   clk          in   1        block clock
//   rst_n        in   1        asynchronous reset, active-low
//   arm          in   1        request one measurement (IDLE / HOLD handshake)
//   from_in      in   1        async reference; rising edge starts counting
//   to_in        in   1        async response; rising edge stops counting
//   busy         out  1        registered, high whenever state != IDLE
//   res_valid    out  1        result available
//   res_ready    in   1        consumer accepts the result
//   res_delay    out  CNT_W    measured delay in cycles (TIMEOUT on timeout)
//   res_timeout  out  1        result is a timeout
//   acc_clr      in   1        (DELAY_ACCUM_EN) synchronous accumulator clear
//   acc_sum      out  CNT_W+8  (DELAY_ACCUM_EN) sum of accepted delays
//   acc_n        out  8        (DELAY_ACCUM_EN) number of accepted delays
//
// Optional feature macro: DELAY_ACCUM_EN
//   When defined, non-timeout results accepted by the consumer are summed
//   into acc_sum and counted in acc_n. acc_n saturates at 255, after which
//   both registers freeze until acc_clr or reset.
// ============================================================================
module edge_delay_counter #(
  parameter int CNT_W        = 16,
  parameter int TIMEOUT      = 1000,
  parameter int SYNC_STAGES  = 2,
  parameter int STRICT_ORDER = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             arm,
  input  logic             from_in,
  input  logic             to_in,
  output logic             busy,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [CNT_W-1:0] res_delay,
  output logic             res_timeout
`ifdef DELAY_ACCUM_EN
  ,
  input  logic             acc_clr,
  output logic [CNT_W+7:0] acc_sum,
  output logic [7:0]       acc_n
`endif
);

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_FROM = 2'd1,
    COUNT     = 2'd2,
    HOLD      = 2'd3
  } state_t;

  state_t state;

  // --------------------------------------------------------------------------
  // Synchronizers and rising-edge detection. Both paths have the same depth,
  // so a fixed input-to-detect latency cancels out of the measured delay.
  // --------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] from_sync;
  logic [SYNC_STAGES-1:0] to_sync;
  logic                   from_prev;
  logic                   to_prev;
  logic                   from_edge;
  logic                   to_edge;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      from_sync <= '0;
      to_sync   <= '0;
      from_prev <= 1'b0;
      to_prev   <= 1'b0;
    end else begin
      from_sync <= {from_sync[SYNC_STAGES-2:0], from_in};
      to_sync   <= {to_sync[SYNC_STAGES-2:0], to_in};
      from_prev <= from_sync[SYNC_STAGES-1];
      to_prev   <= to_sync[SYNC_STAGES-1];
    end
  end

  assign from_edge = from_sync[SYNC_STAGES-1] & ~from_prev;
  assign to_edge   = to_sync[SYNC_STAGES-1] & ~to_prev;

  // --------------------------------------------------------------------------
  // Measurement FSM. cnt holds (cycles since from-edge detect) - 1, so the
  // result on a to-edge is cnt+1. TIMEOUT fits in CNT_W bits, so cnt+1 never
  // wraps before the timeout compare fires.
  // --------------------------------------------------------------------------
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             handshake;

  assign cnt_inc   = cnt + ONE_C;
  assign handshake = (state == HOLD) & res_valid & res_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      busy        <= 1'b0;
      res_valid   <= 1'b0;
      res_delay   <= '0;
      res_timeout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (arm) begin
            state <= WAIT_FROM;
            busy  <= 1'b1;
          end
        end

        WAIT_FROM: begin
          if (from_edge) begin
            cnt <= '0;
            // A coincident to-edge either completes at zero delay or is
            // dropped, depending on whether strict ordering is required.
            if ((STRICT_ORDER == 0) && to_edge) begin
              state       <= HOLD;
              res_valid   <= 1'b1;
              res_delay   <= '0;
              res_timeout <= 1'b0;
            end else begin
              state <= COUNT;
            end
          end
        end

        COUNT: begin
          if (to_edge) begin
            state       <= HOLD;
            res_valid   <= 1'b1;
            res_delay   <= cnt_inc;
            res_timeout <= 1'b0;
          end else if (cnt_inc == TIMEOUT_C) begin
            state       <= HOLD;
            res_valid   <= 1'b1;
            res_delay   <= TIMEOUT_C;
            res_timeout <= 1'b1;
          end else begin
            cnt <= cnt_inc;
          end
        end

        HOLD: begin
          // Result registers stay untouched until the consumer takes them.
          if (handshake) begin
            res_valid <= 1'b0;
            if (arm) begin
              state <= WAIT_FROM;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end

        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          res_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef DELAY_ACCUM_EN
  // --------------------------------------------------------------------------
  // Accumulator of accepted, non-timeout delays. Freezes once acc_n reaches
  // 255 so the sum always corresponds to the reported count.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_sum <= '0;
      acc_n   <= '0;
    end else if (acc_clr) begin
      acc_sum <= '0;
      acc_n   <= '0;
    end else if (handshake && !res_timeout && (acc_n != 8'hFF)) begin
      acc_sum <= acc_sum + {8'd0, res_delay};
      acc_n   <= acc_n + 8'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_edge_delay_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_edge_delay_counter
// Purpose  : Directed self-checking bench for edge_delay_counter. dut0 uses
//            the default parameters (STRICT_ORDER=1, TIMEOUT=1000); dut1 is a
//            STRICT_ORDER=0 instance sharing clk/rst_n/from_in/to_in but with
//            its own arm/ready, used for the coincident-edge case.
// Revision : 1.0 - initial release
// ============================================================================
module tb_edge_delay_counter;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             arm = 1'b0;
  logic             from_in = 1'b0;
  logic             to_in = 1'b0;
  logic             res_ready = 1'b0;
  logic             busy;
  logic             res_valid;
  logic [CNT_W-1:0] res_delay;
  logic             res_timeout;

  logic             arm1 = 1'b0;
  logic             res_ready1 = 1'b0;
  logic             busy1;
  logic             res_valid1;
  logic [CNT_W-1:0] res_delay1;
  logic             res_timeout1;

`ifdef DELAY_ACCUM_EN
  logic             acc_clr = 1'b0;
  logic [CNT_W+7:0] acc_sum;
  logic [7:0]       acc_n;
  logic [CNT_W+7:0] acc_sum1;
  logic [7:0]       acc_n1;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  edge_delay_counter #(
    .CNT_W(CNT_W), .TIMEOUT(1000), .SYNC_STAGES(2), .STRICT_ORDER(1)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .arm(arm), .from_in(from_in), .to_in(to_in),
    .busy(busy), .res_valid(res_valid), .res_ready(res_ready),
    .res_delay(res_delay), .res_timeout(res_timeout)
`ifdef DELAY_ACCUM_EN
    , .acc_clr(acc_clr), .acc_sum(acc_sum), .acc_n(acc_n)
`endif
  );

  edge_delay_counter #(
    .CNT_W(CNT_W), .TIMEOUT(1000), .SYNC_STAGES(2), .STRICT_ORDER(0)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .arm(arm1), .from_in(from_in), .to_in(to_in),
    .busy(busy1), .res_valid(res_valid1), .res_ready(res_ready1),
    .res_delay(res_delay1), .res_timeout(res_timeout1)
`ifdef DELAY_ACCUM_EN
    , .acc_clr(1'b0), .acc_sum(acc_sum1), .acc_n(acc_n1)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for dut0 res_valid.
  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!res_valid && n < 50) begin
      tick();
      n++;
    end
    check({tag, "_valid"}, 32'(res_valid), 32'd1);
  endtask

  // Accept the dut0 result, optionally re-arming in the same cycle.
  task automatic handshake(input logic arm_next, input string tag);
    res_ready = 1'b1;
    arm       = arm_next;
    tick();
    res_ready = 1'b0;
    arm       = 1'b0;
    check({tag, "_valid_drop"}, 32'(res_valid), 32'd0);
    check({tag, "_busy_after"}, 32'(busy), 32'(arm_next));
    repeat (4) tick();
  endtask

  // One full measurement on dut0 with from->to spacing of d input cycles.
  task automatic measure(input int d, input string tag);
    arm = 1'b1;
    tick();
    arm = 1'b0;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    from_in = 1'b1;
    repeat (d) tick();
    to_in = 1'b1;
    wait_valid(tag);
    check({tag, "_delay"}, 32'(res_delay), 32'(d));
    check({tag, "_tmo"}, 32'(res_timeout), 32'd0);
    check({tag, "_busy_hold"}, 32'(busy), 32'd1);
    from_in = 1'b0;
    to_in   = 1'b0;
    handshake(1'b0, tag);
  endtask

  // From-edge with no response: result after 2 sync + 1 detect + 1000 cycles.
  task automatic run_timeout(input string tag);
    int n;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    from_in = 1'b1;
    n = 0;
    while (!res_valid && n < 1100) begin
      tick();
      n++;
    end
    check({tag, "_latency"}, 32'(n), 32'd1003);
    check({tag, "_delay"}, 32'(res_delay), 32'd1000);
    check({tag, "_tmo"}, 32'(res_timeout), 32'd1);
    from_in = 1'b0;
    handshake(1'b0, tag);
  endtask

  initial begin
    // ---------------- reset state ----------------
    rst_n = 1'b0;
    repeat (2) tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(res_valid), 32'd0);
    check("rst_delay", 32'(res_delay), 32'd0);
    check("rst_tmo", 32'(res_timeout), 32'd0);
    rst_n = 1'b1;
    repeat (2) tick();

    // ---------------- idle ignores edges ----------------
    from_in = 1'b1;
    repeat (3) tick();
    to_in = 1'b1;
    repeat (5) tick();
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_valid", 32'(res_valid), 32'd0);
    from_in = 1'b0;
    to_in   = 1'b0;
    repeat (4) tick();

    // ---------------- basic delay 7 ----------------
    measure(7, "basic7");

    // ---------------- timeout ----------------
    run_timeout("timeout");

    // ---------------- coincident edges ----------------
    arm  = 1'b1;
    arm1 = 1'b1;
    tick();
    arm  = 1'b0;
    arm1 = 1'b0;
    from_in = 1'b1;
    to_in   = 1'b1;
    tick();
    tick();
    to_in = 1'b0;
    tick();
    check("lax_valid", 32'(res_valid1), 32'd1);
    check("lax_delay", 32'(res_delay1), 32'd0);
    check("lax_tmo", 32'(res_timeout1), 32'd0);
    check("strict_no_valid", 32'(res_valid), 32'd0);
    res_ready1 = 1'b1;
    tick();
    res_ready1 = 1'b0;
    check("lax_valid_drop", 32'(res_valid1), 32'd0);
    check("lax_busy_after", 32'(busy1), 32'd0);
    tick();
    to_in = 1'b1;
    wait_valid("strict");
    check("strict_delay", 32'(res_delay), 32'd5);
    check("strict_tmo", 32'(res_timeout), 32'd0);
    from_in = 1'b0;
    to_in   = 1'b0;
    handshake(1'b0, "strict");

    // ---------------- backpressure ----------------
    arm = 1'b1;
    tick();
    arm = 1'b0;
    from_in = 1'b1;
    repeat (7) tick();
    to_in = 1'b1;
    wait_valid("bp");
    from_in = 1'b0;
    to_in   = 1'b0;
    for (int i = 0; i < 20; i++) begin
      from_in = i[1];
      to_in   = i[2];
      tick();
    end
    check("bp_hold_valid", 32'(res_valid), 32'd1);
    check("bp_hold_delay", 32'(res_delay), 32'd7);
    check("bp_hold_tmo", 32'(res_timeout), 32'd0);
    from_in = 1'b0;
    to_in   = 1'b0;
    repeat (5) tick();
    check("bp_hold_delay2", 32'(res_delay), 32'd7);
    handshake(1'b1, "bp");
    // Re-armed straight into WAIT_FROM: next measurement without arm.
    from_in = 1'b1;
    repeat (3) tick();
    to_in = 1'b1;
    wait_valid("bp_next");
    check("bp_next_delay", 32'(res_delay), 32'd3);
    from_in = 1'b0;
    to_in   = 1'b0;
    handshake(1'b0, "bp_next");

    // ---------------- reset mid-count ----------------
    arm = 1'b1;
    tick();
    arm = 1'b0;
    from_in = 1'b1;
    repeat (43) tick();
    check("mid_busy_before", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_valid", 32'(res_valid), 32'd0);
    check("mid_rst_delay", 32'(res_delay), 32'd0);
    check("mid_rst_tmo", 32'(res_timeout), 32'd0);
    from_in = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) tick();
    check("post_rst_idle", 32'(busy), 32'd0);
    measure(9, "post_rst");

`ifdef DELAY_ACCUM_EN
    // ---------------- accumulation ----------------
    acc_clr = 1'b1;
    tick();
    acc_clr = 1'b0;
    check("acc_clr0_sum", 32'(acc_sum), 32'd0);
    check("acc_clr0_n", 32'(acc_n), 32'd0);
    measure(3, "acc3");
    measure(4, "acc4");
    measure(5, "acc5");
    run_timeout("acc_tmo");
    check("acc_sum", 32'(acc_sum), 32'd12);
    check("acc_n", 32'(acc_n), 32'd3);
    acc_clr = 1'b1;
    tick();
    acc_clr = 1'b0;
    check("acc_clr_sum", 32'(acc_sum), 32'd0);
    check("acc_clr_n", 32'(acc_n), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
